// File: rtl/led_step_ctrl.sv
// led_step_ctrl: debounced button sequencer driving a WIDTH-bit LED counter through a 4-state mode FSM.
// Define LED_GRAY_EN to present the internal binary count on LED as Gray code.
module led_step_ctrl #(
    parameter int unsigned WIDTH             = 6,
    parameter int unsigned DEBOUNCE_CYCLES   = 16,
    parameter int unsigned LONG_PRESS_CYCLES = 64,
    parameter int unsigned TICK_DIV          = 8
) (
    input  logic             CLK,
    input  logic             BTN_RST,
    input  logic             BTN_C,
    output logic [WIDTH-1:0] LED,
    output logic [1:0]       STATE,
    output logic             STEP
);
    localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HW  = $clog2(LONG_PRESS_CYCLES + 1);
    localparam int unsigned TW  = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN_UP = 2'b01,
        RUN_DN = 2'b10,
        PAUSE  = 2'b11
    } state_t;

    logic           sync0, sync1, btn_db;
    logic [DBW-1:0] db_cnt;
    logic [HW-1:0]  hold_cnt;
    logic           ev_short, ev_long;

    state_t           state;
    logic             dir_dn;
    logic [WIDTH-1:0] count, count_up, count_dn;
    logic [TW-1:0]    pre;
    logic             tick;

    function automatic logic [WIDTH-1:0] enc(input logic [WIDTH-1:0] b);
`ifdef LED_GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    assign count_up = count + WIDTH'(1);
    assign count_dn = count - WIDTH'(1);
    assign tick     = (pre == TW'(TICK_DIV - 1));
    assign STATE    = state;

    always_ff @(posedge CLK or posedge BTN_RST) begin
        if (BTN_RST) begin
            sync0  <= 1'b0;
            sync1  <= 1'b0;
            btn_db <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync0 <= BTN_C;
            sync1 <= sync0;
            if (sync1 != btn_db) begin
                if (db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    btn_db <= sync1;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DBW'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // hold_cnt sits at LONG_PRESS_CYCLES once the long event has fired, which suppresses SHORT on release
    always_ff @(posedge CLK or posedge BTN_RST) begin
        if (BTN_RST) begin
            hold_cnt <= '0;
            ev_short <= 1'b0;
            ev_long  <= 1'b0;
        end else if (btn_db) begin
            if (hold_cnt != HW'(LONG_PRESS_CYCLES))
                hold_cnt <= hold_cnt + HW'(1);
            ev_long  <= (hold_cnt == HW'(LONG_PRESS_CYCLES - 1));
            ev_short <= 1'b0;
        end else begin
            hold_cnt <= '0;
            ev_long  <= 1'b0;
            ev_short <= (hold_cnt != '0) && (hold_cnt != HW'(LONG_PRESS_CYCLES));
        end
    end

    always_ff @(posedge CLK or posedge BTN_RST) begin
        if (BTN_RST) begin
            state  <= IDLE;
            dir_dn <= 1'b0;
            count  <= '0;
            LED    <= '0;
            STEP   <= 1'b0;
            pre    <= '0;
        end else begin
            STEP <= 1'b0;
            case (state)
                IDLE: begin
                    pre <= '0;
                    if (ev_short) begin
                        count <= count_up;
                        LED   <= enc(count_up);
                        STEP  <= 1'b1;
                    end else if (ev_long) begin
                        state  <= RUN_UP;
                        dir_dn <= 1'b0;
                    end
                end
                RUN_UP, RUN_DN: begin
                    // a button event pre-empts a coincident tick
                    if (ev_short) begin
                        state <= PAUSE;
                        pre   <= '0;
                    end else if (ev_long) begin
                        state  <= (state == RUN_UP) ? RUN_DN : RUN_UP;
                        dir_dn <= (state == RUN_UP);
                        pre    <= '0;
                    end else if (tick) begin
                        pre  <= '0;
                        STEP <= 1'b1;
                        if (state == RUN_UP) begin
                            count <= count_up;
                            LED   <= enc(count_up);
                        end else begin
                            count <= count_dn;
                            LED   <= enc(count_dn);
                        end
                    end else begin
                        pre <= pre + TW'(1);
                    end
                end
                PAUSE: begin
                    pre <= '0;
                    if (ev_short) begin
                        state <= dir_dn ? RUN_DN : RUN_UP;
                    end else if (ev_long) begin
                        state <= IDLE;
                        if (count != '0) begin
                            count <= '0;
                            LED   <= '0;
                            STEP  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
